// File: rtl/route_arb_1536_pkg.sv
// route_pkg: shared constants and types for the route_arb_1536 slice.
//
// Contents:
//   DATA_W_1536 - width of one routing beat in bits
//   LAST_W_12   - per-lane tlast vector width (one bit per 128-bit lane)
//   LANE_W      - width of one downstream lane
//   arb_state_e - arbiter FSM states (ARB_IDLE, ARB_LOCK)
//
// Optional feature macro used elsewhere in the slice: ROUTE_ARB_TID_EN.
package route_pkg;

  localparam int DATA_W_1536 = 1536;
  localparam int LAST_W_12   = 12;
  localparam int LANE_W      = 128;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/route_arb_1536_if.sv
// route_arb_1536_if: AXI-Stream bundle around the packet arbiter.
//
// Signals:
//   s_axis_tdata  [NUM_SRC*DATA_W] source i at [i*DATA_W +: DATA_W]
//   s_axis_tvalid [NUM_SRC]        per-source valid
//   s_axis_tready [NUM_SRC]        per-source ready (at most one high)
//   s_axis_tlast  [NUM_SRC*LAST_W] per-source per-lane tlast vector
//   m_axis_tdata  [DATA_W]         arbitrated beat
//   m_axis_tvalid                  output valid
//   m_axis_tready                  downstream ready
//   m_axis_tlast  [LAST_W]         tlast vector of the output beat
//   m_axis_tid    [clog2(NUM_SRC)] source index of the output beat
//                                  (only when ROUTE_ARB_TID_EN is defined)
//
// Modports:
//   master - the surroundings: drives sources and downstream ready
//   slave  - the arbiter itself
interface route_arb_1536_if
  import route_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = DATA_W_1536,
  parameter int LAST_W  = LAST_W_12
);

  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [NUM_SRC*LAST_W-1:0] s_axis_tlast;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [LAST_W-1:0]         m_axis_tlast;
`ifdef ROUTE_ARB_TID_EN
  logic [$clog2(NUM_SRC)-1:0] m_axis_tid;
`endif

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
`ifdef ROUTE_ARB_TID_EN
    , input m_axis_tid
`endif
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
`ifdef ROUTE_ARB_TID_EN
    , output m_axis_tid
`endif
  );

endinterface

// File: rtl/route_arb_1536_skid.sv
// route_skid_buf: 2-entry registered FIFO used as the output stage of the
// arbiter so that no combinational path crosses the wide datapath.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     write request
//   in_ready     registered "not full"
//   in_data [W]  payload ({tid?, tlast, tdata} in the arbiter)
//   out_valid    "not empty"
//   out_ready    downstream ready
//   out_data [W] head entry (zero after reset)
module route_skid_buf
  import route_pkg::*;
#(
  parameter int W = DATA_W_1536 + LAST_W_12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        count_q, count_d;
  logic              ready_q, ready_d;
  logic              push, pop;

  // Ready is a flop computed from the next occupancy, so a push and a pop
  // can never meet while the buffer is full.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    push    = in_valid & ready_q;
    pop     = (count_q != 2'd0) & out_ready;
    if (push) begin
      mem_d[wr_q] = in_data;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_q];

endmodule

// File: rtl/route_arb_1536.sv
// route_arb_1536: packet-granular round-robin arbiter sharing one 1536-bit
// routing datapath between NUM_SRC AXI-Stream producers. A source keeps the
// grant until it delivers a beat whose tlast vector is nonzero. The output
// passes through a 2-entry registered skid buffer.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          route_arb_1536_if.slave (source and master AXI-Stream)
//   grant_valid  high while a packet is locked
//   grant_idx    locked source; holds its last value while idle
//   pkt_done     pulse when the final beat of a packet is accepted
//
// Optional feature: define ROUTE_ARB_TID_EN to add bus.m_axis_tid, the
// source index of each output beat carried through the skid buffer.
module route_arb_1536
  import route_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = DATA_W_1536,
  parameter int LAST_W  = LAST_W_12,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  route_arb_1536_if.slave  bus,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             pkt_done
);

  // First requester strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

`ifdef ROUTE_ARB_TID_EN
  localparam int STORE_W = IDX_W + LAST_W + DATA_W;
`else
  localparam int STORE_W = LAST_W + DATA_W;
`endif

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0] s_tready;
  logic               push;
  logic               buf_in_ready;
  logic               g_valid;
  logic [LAST_W-1:0]  g_last;
  logic [DATA_W-1:0]  g_data;
  logic [STORE_W-1:0] buf_in, buf_out;

  assign g_valid = bus.s_axis_tvalid[grant_q];
  assign g_last  = bus.s_axis_tlast[grant_q*LAST_W +: LAST_W];
  assign g_data  = bus.s_axis_tdata[grant_q*DATA_W +: DATA_W];

  // IDLE picks the next requester; LOCK streams that source into the skid
  // buffer until a beat with any tlast bit set is accepted.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    s_tready = '0;
    push     = 1'b0;
    pkt_done = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|bus.s_axis_tvalid) begin
          grant_d = rr_pick(bus.s_axis_tvalid, rr_ptr_q);
          state_d = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        s_tready[grant_q] = buf_in_ready;
        push              = g_valid & buf_in_ready;
        if (push && (|g_last)) begin
          pkt_done = 1'b1;
          rr_ptr_d = grant_q;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // rr_ptr resets to the top index so source 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.s_axis_tready = s_tready;
  assign grant_valid       = (state_q == ARB_LOCK);
  assign grant_idx         = grant_q;

`ifdef ROUTE_ARB_TID_EN
  assign buf_in = {grant_q, g_last, g_data};
  assign {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata} = buf_out;
`else
  assign buf_in = {g_last, g_data};
  assign {bus.m_axis_tlast, bus.m_axis_tdata} = buf_out;
`endif

  route_skid_buf #(
    .W (STORE_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push),
    .in_ready  (buf_in_ready),
    .in_data   (buf_in),
    .out_valid (bus.m_axis_tvalid),
    .out_ready (bus.m_axis_tready),
    .out_data  (buf_out)
  );

endmodule

// File: tb/tb_route_arb_1536.sv
// tb_route_arb_1536: randomized scoreboard bench for route_arb_1536.
// Source queues are loaded per phase; a packet-level round-robin model
// predicts the output beat stream and the grant sequence, and a monitor
// compares them against the DUT whenever a beat or pkt_done appears.
`timescale 1ns/1ps
module tb_route_arb_1536;
  import route_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = DATA_W_1536;
  localparam int LAST_W  = LAST_W_12;
  localparam int IDX_W   = $clog2(NUM_SRC);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LAST_W-1:0] last;
    logic [7:0]        src;
  } beat_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             pkt_done;

  route_arb_1536_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .LAST_W(LAST_W)) bus ();

  route_arb_1536 #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .LAST_W(LAST_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .pkt_done    (pkt_done)
  );

  always #5 clk = ~clk;

  beat_t src_q[NUM_SRC][$];
  beat_t mod_beats[NUM_SRC][$];
  beat_t exp_q[$];
  int    exp_grant[$];
  int    model_ptr = NUM_SRC - 1;
  int    checks    = 0;
  int    failures  = 0;
  bit    in_pkt[NUM_SRC];
  int    stall_cnt[NUM_SRC];
  int    hold_low   = 0;
  bit    rand_drop  = 1'b0;
  bit    rand_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual[63:0]=0x%h required[63:0]=0x%h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic addBeat(input int src, input logic [DATA_W-1:0] data, input logic [LAST_W-1:0] last);
    beat_t b;
    b.data = data;
    b.last = last;
    b.src  = 8'(src);
    src_q[src].push_back(b);
    mod_beats[src].push_back(b);
  endtask

  // Queue one random packet of nbeats on source src; only the final beat has tlast.
  task automatic applyStimulus(input int src, input int nbeats);
    logic [DATA_W-1:0] d;
    logic [LAST_W-1:0] l;
    for (int b = 0; b < nbeats; b++) begin
      for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
      l = (b == nbeats - 1) ? LAST_W'($urandom_range(1, (1 << LAST_W) - 1)) : '0;
      addBeat(src, d, l);
    end
  endtask

  // Packet-level reference: whole packets in round-robin order after the last winner.
  task automatic runModel();
    int    nxt;
    beat_t b;
    while (1) begin
      nxt = -1;
      for (int k = 1; k <= NUM_SRC; k++)
        if (nxt < 0 && mod_beats[(model_ptr + k) % NUM_SRC].size() > 0)
          nxt = (model_ptr + k) % NUM_SRC;
      if (nxt < 0) break;
      exp_grant.push_back(nxt);
      do begin
        b = mod_beats[nxt].pop_front();
        exp_q.push_back(b);
      end while (b.last == '0);
      model_ptr = nxt;
    end
  endtask

  task automatic flushAll();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_q[i].delete();
      mod_beats[i].delete();
      in_pkt[i]    = 1'b0;
      stall_cnt[i] = 0;
    end
    exp_q.delete();
    exp_grant.delete();
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || exp_grant.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0 || exp_grant.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout pending_beats=%0d pending_grants=%0d required=0",
               exp_q.size(), exp_grant.size());
      flushAll();
    end
    repeat (3) @(negedge clk);
  endtask

  // Source and downstream driver: update inputs 1 ns after each rising edge.
  initial begin
    logic [NUM_SRC-1:0] acc;
    beat_t              b;
    bit                 v;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      in_pkt[i]    = 1'b0;
      stall_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      acc = bus.s_axis_tvalid & bus.s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (rst_n && acc[i] && src_q[i].size() > 0) begin
          b         = src_q[i].pop_front();
          in_pkt[i] = (b.last == '0);
        end
        if (!rst_n || src_q[i].size() == 0) v = 1'b0;
        else if (stall_cnt[i] > 0) begin
          v = 1'b0;
          stall_cnt[i]--;
        end else if (in_pkt[i] && rand_drop && ($urandom % 4 == 0)) v = 1'b0;
        else v = 1'b1;
        bus.s_axis_tvalid[i] = v;
        if (src_q[i].size() > 0) begin
          bus.s_axis_tdata[i*DATA_W +: DATA_W] = src_q[i][0].data;
          bus.s_axis_tlast[i*LAST_W +: LAST_W] = src_q[i][0].last;
        end else begin
          bus.s_axis_tdata[i*DATA_W +: DATA_W] = '0;
          bus.s_axis_tlast[i*LAST_W +: LAST_W] = '0;
        end
      end
      if (hold_low > 0) begin
        bus.m_axis_tready = 1'b0;
        hold_low--;
      end else if (rand_ready) bus.m_axis_tready = ($urandom % 3 != 0);
      else bus.m_axis_tready = 1'b1;
    end
  end

  // Monitor: scoreboard pops on output handshakes and on pkt_done.
  initial begin
    beat_t       e;
    int          g;
    bit          prev_done;
    logic [63:0] rdy_exp;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_done = 1'b0;
      else begin
        if (bus.s_axis_tready != '0) begin
          rdy_exp = 64'(1) << grant_idx;
          checkOutput("tready_only_granted", 64'(bus.s_axis_tready), rdy_exp);
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_beat tdata[63:0]=0x%h required=none", bus.m_axis_tdata[63:0]);
          end else begin
            e = exp_q.pop_front();
            checkData("m_tdata", bus.m_axis_tdata, e.data);
            checkOutput("m_tlast", 64'(bus.m_axis_tlast), 64'(e.last));
`ifdef ROUTE_ARB_TID_EN
            checkOutput("m_tid", 64'(bus.m_axis_tid), 64'(e.src));
`endif
          end
        end
        if (pkt_done) begin
          if (exp_grant.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_pkt_done grant_idx=%0d required=none", grant_idx);
          end else begin
            g = exp_grant.pop_front();
            checkOutput("grant_order", 64'(grant_idx), 64'(g));
          end
        end
        if (prev_done) checkOutput("idle_bubble", 64'(grant_valid), 64'd0);
        prev_done = pkt_done;
      end
    end
  end

  // Main sequence of directed and randomized phases.
  initial begin
    logic [DATA_W-1:0] pa, pb, pc;
    bit                seen;
    int                n;

    // Reset and idle behaviour
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    checkData("rst_m_tdata", bus.m_axis_tdata, '0);
    checkOutput("rst_m_tlast", 64'(bus.m_axis_tlast), 64'd0);
    checkOutput("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
    checkOutput("rst_grant_valid", 64'(grant_valid), 64'd0);
    checkOutput("rst_grant_idx", 64'(grant_idx), 64'd0);
    checkOutput("rst_pkt_done", 64'(pkt_done), 64'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_no_grant", 64'(grant_valid), 64'd0);
      checkOutput("idle_no_mvalid", 64'(bus.m_axis_tvalid), 64'd0);
    end

    // Round robin from reset: expected grants 0,1,2,3,0
    $display("[TB] phase round_robin");
    applyStimulus(0, 2);
    applyStimulus(1, 2);
    applyStimulus(2, 2);
    applyStimulus(3, 2);
    applyStimulus(0, 2);
    runModel();
    waitDrain(200);

    // Single source, three beats, with latency checks
    $display("[TB] phase single_source");
    pa = {(DATA_W/4){4'hA}};
    pb = {(DATA_W/4){4'hB}};
    pc = {(DATA_W/4){4'hC}};
    addBeat(2, pa, 12'h000);
    addBeat(2, pb, 12'h000);
    addBeat(2, pc, 12'h800);
    runModel();
    @(negedge clk);
    checkOutput("lat_T_tvalid", 64'(bus.s_axis_tvalid), 64'h4);
    checkOutput("lat_T_grant_valid", 64'(grant_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_T1_grant_valid", 64'(grant_valid), 64'd1);
    checkOutput("lat_T1_grant_idx", 64'(grant_idx), 64'd2);
    checkOutput("lat_T1_tready", 64'(bus.s_axis_tready), 64'h4);
    @(negedge clk);
    checkOutput("lat_T2_m_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    waitDrain(100);

    // Backpressure: downstream ready low for 5 cycles mid-packet
    $display("[TB] phase backpressure");
    applyStimulus(0, 10);
    runModel();
    n = 0;
    while (exp_q.size() > 7 && n < 50) begin
      @(negedge clk);
      n++;
    end
    hold_low = 5;
    @(negedge clk);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.s_axis_tready[0] == 1'b0) seen = 1'b1;
    end
    checkOutput("bp_tready_low_within_2", 64'(seen), 64'd1);
    waitDrain(200);

    // Mid-packet stall of the granted source while others request
    $display("[TB] phase mid_packet_stall");
    applyStimulus(1, 6);
    runModel();
    n = 0;
    while (!in_pkt[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    applyStimulus(0, 2);
    applyStimulus(3, 2);
    runModel();
    stall_cnt[1] = 4;
    repeat (4) begin
      @(negedge clk);
      checkOutput("stall_grant_valid", 64'(grant_valid), 64'd1);
      checkOutput("stall_grant_idx", 64'(grant_idx), 64'd1);
    end
    waitDrain(200);

    // Randomized traffic with source gaps and downstream backpressure
    $display("[TB] phase random");
    rand_drop  = 1'b1;
    rand_ready = 1'b1;
    repeat (8) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        n = $urandom_range(0, 2);
        repeat (n) applyStimulus(i, $urandom_range(1, 5));
      end
      runModel();
      waitDrain(800);
    end
    rand_drop  = 1'b0;
    rand_ready = 1'b0;

    // Reset in the middle of a src3 packet
    $display("[TB] phase reset_mid_packet");
    applyStimulus(3, 4);
    runModel();
    n = 0;
    while (!in_pkt[3] && n < 50) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    checkData("mrst_m_tdata", bus.m_axis_tdata, '0);
    checkOutput("mrst_m_tlast", 64'(bus.m_axis_tlast), 64'd0);
    checkOutput("mrst_grant_valid", 64'(grant_valid), 64'd0);
    checkOutput("mrst_s_tready", 64'(bus.s_axis_tready), 64'd0);
    flushAll();
    model_ptr = NUM_SRC - 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1, 2);
    applyStimulus(0, 2);
    applyStimulus(3, 1);
    runModel();
    n = 0;
    while (!grant_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first_grant_after_reset", 64'(grant_idx), 64'd0);
    waitDrain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
